reg_bank_periph: RTL and testbench

Parametrised register-bank peripheral with a valid/ready request channel and a valid/ready response channel. It replaces the fixed 4×4-bit register bank behind the bus arbiter. It generalises data width and depth, flags out-of-range accesses as errors, and keeps an error counter. It holds at most one response, and it can accept a new request in the same cycle that the pending response is consumed.

---
 rtl/reg_bank_periph.sv | 112 +++++++++++
 tb/tb_reg_bank_periph.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_periph.sv
// Parametrised register bank behind a valid/ready request and valid/ready response channel.
// Latency: a request accepted at edge N shows its response in cycle N+1; one access per cycle.
// Backpressure: holds at most one response; req_ready = EMPTY || rsp_ready (new accept replaces a consumed response).
// Optional REG_BANK_WMASK_EN adds req_wmask and per-bit masked writes; default build writes full registers.
module reg_bank_periph #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
`ifdef REG_BANK_WMASK_EN
    input  logic [DATA_W-1:0]   req_wmask,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ERRCNT_W-1:0] err_count
);

    // Response-slot occupancy
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]          r_state;
    logic [DATA_W-1:0]   r_regs [DEPTH];
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic [ERRCNT_W-1:0] r_err_count;

    logic                w_accept;
    logic                w_consume;
    logic                w_in_range;
    logic [DATA_W-1:0]   w_rd_data;
    logic [DATA_W-1:0]   w_wr_data;

    // Handshake decode; req_ready never looks at req_valid so no comb loop with the requester
    always_comb begin
        req_ready  = (r_state == S_EMPTY) || rsp_ready;
        rsp_valid  = (r_state == S_FULL);
        w_accept   = req_valid && req_ready;
        w_consume  = rsp_valid && rsp_ready;
        // Zero-extend the address before comparing so non-power-of-two depths trap the top codes
        w_in_range = (32'(req_addr) < 32'(DEPTH));
    end

    // Read mux and write-data merge; out-of-range addresses never index the array
    always_comb begin
        w_rd_data = '0;
        if (w_in_range) begin
            w_rd_data = r_regs[req_addr];
        end
`ifdef REG_BANK_WMASK_EN
        w_wr_data = (w_rd_data & ~req_wmask) | (req_wdata & req_wmask);
`else
        w_wr_data = req_wdata;
`endif
    end

    // Register array: cleared on reset, changed only by accepted in-range writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_accept && req_wr && w_in_range) begin
            r_regs[req_addr] <= w_wr_data;
        end
    end

    // Response slot: a new accept overwrites (and so also retires) the held response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_state     <= S_FULL;
            // Read data is the pre-write value; writes and errors return zero
            r_rsp_rdata <= (req_wr || !w_in_range) ? '0 : w_rd_data;
            r_rsp_err   <= !w_in_range;
        end else if (w_consume) begin
            r_state     <= S_EMPTY;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end
    end

    // Saturating count of error responses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_accept && !w_in_range && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    // Output drive
    always_comb begin
        rsp_rdata = r_rsp_rdata;
        rsp_err   = r_rsp_err;
        err_count = r_err_count;
    end

endmodule

// File: tb/tb_reg_bank_periph.sv
// Bench for reg_bank_periph with DEPTH=6 so addresses 6 and 7 exercise the error path.
// Expected responses are queued at accept time and compared while the response is held/consumed.
// Works with or without REG_BANK_WMASK_EN defined.
module tb_reg_bank_periph;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 6;
    localparam int ADDR_W   = 3;
    localparam int ERRCNT_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic                req_wr;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W-1:0]   req_wmask;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic [ERRCNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [DATA_W-1:0] m_regs [8];
    logic              m_full;
    int                m_errcnt;
    rsp_t              sb_q [$];

    always #5 clk = ~clk;

    reg_bank_periph #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .ERRCNT_W(ERRCNT_W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
`ifdef REG_BANK_WMASK_EN
        .req_wmask(req_wmask),
`endif
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .err_count(err_count)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_full   = 1'b0;
        m_errcnt = 0;
        sb_q.delete();
    endtask

    // One clock: drive at negedge, check outputs 1ns later, update model, wait for posedge
    task automatic cycle(input logic v, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] wmask,
                         input logic rrdy);
        logic              acc;
        logic              cons;
        logic              in_rng;
        logic [DATA_W-1:0] eff_mask;
        rsp_t              exp_rsp;
        @(negedge clk);
        req_valid = v;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        rsp_ready = rrdy;
        #1;
        check_val("req_ready", 32'(req_ready), 32'(!m_full || rrdy));
        check_val("rsp_valid", 32'(rsp_valid), 32'(m_full));
        check_val("err_count", 32'(err_count), 32'(m_errcnt));
        if (m_full) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                check_val("rsp_rdata", 32'(rsp_rdata), 32'(sb_q[0].rdata));
                check_val("rsp_err", 32'(rsp_err), 32'(sb_q[0].err));
            end
        end else begin
            check_val("idle_rdata", 32'(rsp_rdata), 32'd0);
            check_val("idle_err", 32'(rsp_err), 32'd0);
        end
        acc  = v && (!m_full || rrdy);
        cons = m_full && rrdy;
        if (cons && sb_q.size() != 0) void'(sb_q.pop_front());
        if (acc) begin
            in_rng = (32'(addr) < DEPTH);
`ifdef REG_BANK_WMASK_EN
            eff_mask = wmask;
`else
            eff_mask = '1;
`endif
            exp_rsp.err   = !in_rng;
            exp_rsp.rdata = (wr || !in_rng) ? '0 : m_regs[addr];
            sb_q.push_back(exp_rsp);
            if (wr && in_rng) m_regs[addr] = (m_regs[addr] & ~eff_mask) | (wdata & eff_mask);
            if (!in_rng && m_errcnt < 255) m_errcnt++;
            m_full = 1'b1;
        end else if (cons) begin
            m_full = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic rrdy);
        cycle(1'b1, 1'b0, a, '0, '0, rrdy);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [DATA_W-1:0] m);
        cycle(1'b1, 1'b1, a, d, m, 1'b1);
    endtask

    task automatic drain();
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // One reset edge, with a request presented that must not be accepted
    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 3'd2;
        req_wdata = 8'h77;
        req_wmask = 8'hFF;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        model_reset();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        apply_reset();

        // Reset state with rsp_ready low
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);

        // Read every address back-to-back: zeros in range, errors at 6 and 7
        for (int a = 0; a < 8; a++) do_read(3'(a), 1'b1);
        drain();

        // Write then read back-to-back
        do_write(3'd3, 8'hA5, 8'hFF);
        do_read(3'd3, 1'b1);
        drain();

        // Backpressure: held response, pending write not accepted, then accepted on release
        do_read(3'd3, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 3'd3, 8'h5A, 8'hFF, 1'b0);
        cycle(1'b1, 1'b1, 3'd3, 8'h5A, 8'hFF, 1'b1);
        do_read(3'd3, 1'b1);
        drain();

        // Out-of-range write and read
        do_write(3'd7, 8'h33, 8'hFF);
        do_read(3'd7, 1'b1);
        do_write(3'd6, 8'h44, 8'hFF);
        drain();
        for (int a = 0; a < DEPTH; a++) do_read(3'(a), 1'b1);
        drain();

        // Saturate the error counter
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) do_write(3'd7, 8'(i), 8'hFF);
            else            do_read(3'd7, 1'b1);
        end
        drain();
        check_val("err_sat", 32'(err_count), 32'd255);

        // Masked write (or full write without the mask feature)
        do_write(3'd1, 8'hFF, 8'hFF);
        do_write(3'd1, 8'h00, 8'h0F);
        do_read(3'd1, 1'b1);
        do_write(3'd2, 8'h3C, 8'h00);
        do_read(3'd2, 1'b1);
        drain();

        // Reset while a response is held
        do_write(3'd4, 8'hC3, 8'hFF);
        do_read(3'd4, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
        apply_reset();
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
        for (int a = 0; a < DEPTH; a++) do_read(3'(a), 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
